// File: rtl/flex_counter_ext.sv
// flex_counter_ext: up/down counter with wrap or one-shot mode, synchronous
// load, registered rollover pulse and done flag.
// Optional enable prescaler compiled in with FLEX_CNT_PRESCALE_EN.
module flex_counter_ext #(
    parameter int NUM_CNT_BITS  = 8,
    parameter int PRESCALE_BITS = 4
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     clear,
    input  logic                     count_enable,
    input  logic                     count_up,
    input  logic                     one_shot,
    input  logic                     load,
    input  logic [NUM_CNT_BITS-1:0]  load_val,
    input  logic [NUM_CNT_BITS-1:0]  rollover_val,
    input  logic [PRESCALE_BITS-1:0] prescale_val,
    output logic [NUM_CNT_BITS-1:0]  count_out,
    output logic                     rollover_flag,
    output logic                     rollover_pulse,
    output logic                     done
);

    typedef enum logic {RUN, HALT} state_t;

    localparam logic [NUM_CNT_BITS-1:0] CNT_ONE = {{(NUM_CNT_BITS-1){1'b0}}, 1'b1};

    state_t                  state_q, state_d;
    logic [NUM_CNT_BITS-1:0] count_q, count_d;
    logic                    pulse_q, pulse_d;
    logic                    done_q, done_d;
    logic                    tick;
    logic                    rv_zero;
    logic [NUM_CNT_BITS-1:0] term_val;

    assign rv_zero  = (rollover_val == '0);
    assign term_val = count_up ? rollover_val : CNT_ONE;

    // Next-count value for a step that is not a terminal event.
    function automatic logic [NUM_CNT_BITS-1:0] step_val(
        input logic                    up,
        input logic [NUM_CNT_BITS-1:0] cnt,
        input logic [NUM_CNT_BITS-1:0] rv
    );
        if (up)
            return cnt + CNT_ONE;
        else if (cnt > rv)
            return rv;
        else
            return cnt - CNT_ONE;
    endfunction

    // Whether a tick at the current count is a wrap/halt event.
    function automatic logic is_event(
        input logic                    up,
        input logic [NUM_CNT_BITS-1:0] cnt,
        input logic [NUM_CNT_BITS-1:0] rv
    );
        if (rv == '0)
            return 1'b1;
        else if (up)
            return (cnt >= rv);
        else
            return (cnt <= CNT_ONE);
    endfunction

`ifdef FLEX_CNT_PRESCALE_EN
    logic [PRESCALE_BITS-1:0] psc_q;

    assign tick = count_enable && (psc_q == prescale_val);

    // Prescaler: counts enabled cycles, returns to 0 on each tick.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            psc_q <= '0;
        else if (clear || load)
            psc_q <= '0;
        else if (count_enable)
            psc_q <= tick ? '0 : psc_q + 1'b1;
    end
`else
    logic unused_prescale;

    assign unused_prescale = ^prescale_val;
    assign tick            = count_enable;
`endif

    // State, count, pulse and done registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= RUN;
            count_q <= '0;
            pulse_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            pulse_q <= pulse_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic: clear beats load beats tick; HALT ignores ticks.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        pulse_d = 1'b0;
        done_d  = done_q;
        if (clear) begin
            state_d = RUN;
            count_d = '0;
            done_d  = 1'b0;
        end else if (load) begin
            state_d = RUN;
            count_d = load_val;
            done_d  = 1'b0;
        end else if (tick && (state_q == RUN)) begin
            if (is_event(count_up, count_q, rollover_val)) begin
                pulse_d = 1'b1;
                if (one_shot) begin
                    state_d = HALT;
                    done_d  = 1'b1;
                end else if (rv_zero) begin
                    count_d = '0;
                end else begin
                    count_d = count_up ? CNT_ONE : rollover_val;
                end
            end else begin
                count_d = step_val(count_up, count_q, rollover_val);
            end
        end
    end

    assign count_out      = count_q;
    assign rollover_flag  = (count_q == term_val);
    assign rollover_pulse = pulse_q;
    assign done           = done_q;

endmodule
